// File: rtl/s27_bist_ctrl.sv
// BIST sequencer for the s27 core: an LFSR supplies 4-bit stimulus, dut_step clocks the
// core once per pattern, and the G17 response is compacted into a 16-bit MISR signature.
module s27_bist_ctrl #(
    parameter int unsigned NUM_PATTERNS  = 255,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  LFSR_SEED     = 8'h01
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        start,
    input  logic        resp_in,
    output logic [3:0]  pat_out,
    output logic        dut_step,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic [2:0]  dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_APPLY   = 3'd1,
        S_STEP    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // An all-zero seed would lock the LFSR, so it is promoted to 8'h01.
    localparam logic [7:0]  SEED         = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [15:0] LAST_PATTERN = 16'(NUM_PATTERNS);
    localparam logic [3:0]  LAST_SETTLE  = 4'(SETTLE_CYCLES - 1);

    generate
        if (NUM_PATTERNS < 1 || NUM_PATTERNS > 65535) begin : g_bad_num_patterns
            $error("s27_bist_ctrl: NUM_PATTERNS must be in 1..65535");
        end
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle_cycles
            $error("s27_bist_ctrl: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    state_t      state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [15:0] misr_q, misr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  settle_q, settle_d;

    logic        lfsr_fb;
    logic        misr_fb;
    logic [15:0] cnt_inc;

    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign misr_fb = misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10];
    assign cnt_inc = cnt_q + 16'd1;

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            lfsr_q   <= 8'h00;
            misr_q   <= 16'h0000;
            cnt_q    <= 16'h0000;
            settle_q <= 4'h0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            misr_q   <= misr_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
        end
    end

    // Run protocol: start is a level sampled only in IDLE; done is a one-cycle pulse
    // marking the end of a run, after which signature holds until the next start.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        misr_d   = misr_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_APPLY;
                    lfsr_d   = SEED;
                    misr_d   = 16'h0000;
                    cnt_d    = 16'h0000;
                    settle_d = 4'h0;
                end
            end
            S_APPLY: begin
                settle_d = settle_q + 4'd1;
                if (settle_q == LAST_SETTLE) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                misr_d = {misr_q[14:0], misr_fb ^ resp_in};
                cnt_d  = cnt_inc;
                if (cnt_inc == LAST_PATTERN) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_APPLY;
                    lfsr_d   = {lfsr_q[6:0], lfsr_fb};
                    settle_d = 4'h0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        dut_step    = (state_q == S_STEP);
        busy        = (state_q == S_APPLY) || (state_q == S_STEP) || (state_q == S_CAPTURE);
        done        = (state_q == S_DONE);
        pat_out     = lfsr_q[3:0];
        signature   = misr_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Bench for s27_bist_ctrl: four configurations, randomized responses (including a
// behavioural s27 core), checked cycle by cycle against a pattern-level reference model.
module tb_s27_bist_ctrl;
    localparam int NI = 4;
    localparam int         NUM_P  [NI] = '{255, 1, 2, 7};
    localparam int         SET_P  [NI] = '{2, 2, 2, 3};
    localparam logic [7:0] SEED_P [NI] = '{8'h01, 8'h01, 8'h01, 8'h00};

    logic                  CK = 1'b0;
    logic                  RST;
    logic [NI-1:0]         start;
    logic [NI-1:0]         resp;
    logic [NI-1:0]         step;
    logic [NI-1:0]         busy;
    logic [NI-1:0]         done;
    logic [NI-1:0][3:0]    pat;
    logic [NI-1:0][15:0]   sig;
    logic [NI-1:0][2:0]    dbg;

    logic [15:0]           tab [NI];
    logic [2:0]            cst;
    logic                  core_rst;

    logic [3:0]            exp_q [$];
    logic [3:0]            obs_q [$];
    int                    vec_cnt = 0;
    int                    err_cnt = 0;

    // clock / reset
    always #5 CK = ~CK;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        s27_bist_ctrl #(
            .NUM_PATTERNS (NUM_P[g]),
            .SETTLE_CYCLES(SET_P[g]),
            .LFSR_SEED    (SEED_P[g])
        ) u_dut (
            .CK         (CK),
            .RST        (RST),
            .start      (start[g]),
            .resp_in    (resp[g]),
            .pat_out    (pat[g]),
            .dut_step   (step[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .signature  (sig[g]),
            .dbg_state_o(dbg[g])
        );
    end

    // s27 netlist; returns {G17, G10, G11, G13} for state {G5,G6,G7} and inputs g = {G3..G0}
    function automatic logic [3:0] s27_eval(input logic [2:0] s, input logic [3:0] g);
        logic g5, g6, g7, g8, g9, g10, g11, g12, g13, g14, g15, g16;
        {g5, g6, g7} = s;
        g14 = ~g[0];
        g8  = g14 & g6;
        g12 = ~(g[1] | g7);
        g15 = g12 | g8;
        g16 = g[3] | g8;
        g9  = ~(g16 & g15);
        g11 = ~(g5 | g9);
        g10 = ~(g14 | g11);
        g13 = ~(g[2] | g12);
        return {~g11, g10, g11, g13};
    endfunction

    function automatic logic [7:0] lfsr_adv(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [15:0] misr_adv(input logic [15:0] m, input logic r);
        return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10] ^ r};
    endfunction

    // core beside instance 0 is clocked only by dut_step
    always @(posedge CK) begin
        logic [3:0] e;
        e = s27_eval(cst, pat[0]);
        if (core_rst) cst <= 3'b000;
        else if (step[0]) cst <= e[2:0];
    end

    always_comb begin
        logic [3:0] e;
        resp = '0;
        e = s27_eval(cst, pat[0]);
        resp[0] = e[3];
        for (int i = 1; i < NI; i++) resp[i] = tab[i][pat[i]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full run on instance i, entered from an IDLE cycle before the start edge.
    task automatic run_once(input int i, input bit glitch, input bit keep, output logic [15:0] sig_e);
        int         n_pat, s_cyc, per, tot, k;
        logic [7:0] l;
        logic [2:0] cs;
        logic [3:0] e;
        logic [3:0] p;
        logic       r;
        bit         busy_e, done_e, step_e;
        n_pat = NUM_P[i];
        s_cyc = SET_P[i];
        per   = s_cyc + 2;
        tot   = n_pat * per;
        exp_q.delete();
        obs_q.delete();
        l     = (SEED_P[i] == 8'h00) ? 8'h01 : SEED_P[i];
        cs    = 3'b000;
        sig_e = 16'h0000;
        for (int j = 0; j < n_pat; j++) begin
            p = l[3:0];
            exp_q.push_back(p);
            if (i == 0) begin
                e  = s27_eval(cs, p);
                cs = e[2:0];
                e  = s27_eval(cs, p);
                r  = e[3];
            end else begin
                r = tab[i][p];
            end
            sig_e = misr_adv(sig_e, r);
            l     = lfsr_adv(l);
        end
        start[i] = 1'b1;
        core_rst = 1'b1;
        @(posedge CK);
        #1 core_rst = 1'b0;
        for (int n = 1; n <= tot + 1; n++) begin
            @(negedge CK);
            busy_e = (n <= tot);
            done_e = (n == tot + 1);
            step_e = busy_e && (((n - 1) % per) == s_cyc);
            k      = busy_e ? (n - 1) / per : n_pat - 1;
            check($sformatf("u%0d_cyc%0d", i, n), 32'({pat[i], step[i], busy[i], done[i]}),
                  32'({exp_q[k], step_e, busy_e, done_e}));
            if (n == 1) check($sformatf("u%0d_sig_clr", i), 32'(sig[i]), 32'h0);
            if (step[i]) obs_q.push_back(pat[i]);
            if (done_e) check($sformatf("u%0d_sig_done", i), 32'(sig[i]), 32'(sig_e));
            if (!keep) start[i] = glitch ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        @(negedge CK);
        check($sformatf("u%0d_idle", i), 32'({pat[i], step[i], busy[i], done[i]}),
              32'({exp_q[n_pat - 1], 3'b000}));
        check($sformatf("u%0d_sig_hold", i), 32'(sig[i]), 32'(sig_e));
        start[i] = keep;
    endtask

    task automatic reset_mid_run();
        logic [15:0] dummy;
        int          per;
        per = SET_P[0] + 2;
        tab[3]   = 16'h0;
        start[0] = 1'b1;
        core_rst = 1'b1;
        @(posedge CK);
        #1 core_rst = 1'b0;
        start[0] = 1'b0;
        repeat (10 * per + SET_P[0]) @(posedge CK);
        @(negedge CK);
        check("rst_pre_step", 32'({step[0], busy[0]}), 32'b11);
        RST = 1'b1;
        @(negedge CK);
        check("rst_outs", 32'({pat[0], step[0], busy[0], done[0]}), 32'h0);
        check("rst_sig", 32'(sig[0]), 32'h0);
        repeat (3) begin
            @(negedge CK);
            check("rst_hold", 32'({step, done}), 32'h0);
        end
        RST = 1'b0;
        repeat (5) begin
            @(negedge CK);
            check("rst_after", 32'({done[0], busy[0], step[0]}), 32'h0);
        end
        dummy = 16'h0;
    endtask

    initial begin
        logic [15:0] sig_e;
        logic [15:0] golden;
        logic [3:0]  dir [5];
        logic [31:0] got;
        bit          keep;
        dir      = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        RST      = 1'b1;
        start    = '0;
        core_rst = 1'b0;
        for (int i = 0; i < NI; i++) tab[i] = 16'h0;
        repeat (3) @(posedge CK);
        @(negedge CK);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d_reset", i), 32'({pat[i], step[i], busy[i], done[i], sig[i]}), 32'h0);
        end
        RST = 1'b0;
        @(negedge CK);

        run_once(0, 1'b0, 1'b0, sig_e);
        for (int k = 0; k < 5; k++) begin
            got = (k < obs_q.size()) ? 32'(obs_q[k]) : 32'hFFFF_FFFF;
            check($sformatf("dir_pat%0d", k), got, 32'(dir[k]));
        end
        golden = sig[0];
        run_once(0, 1'b1, 1'b0, sig_e);
        check("golden", 32'(sig[0]), 32'(golden));

        tab[1] = 16'hFFFF;
        run_once(1, 1'b0, 1'b0, sig_e);
        check("one_sig", 32'(sig[1]), 32'h0001);

        tab[2] = 16'hFFFF;
        run_once(2, 1'b1, 1'b1, sig_e);
        check("two_sig_r1", 32'(sig[2]), 32'h0003);
        tab[2] = 16'h0000;
        run_once(2, 1'b1, 1'b0, sig_e);
        check("two_sig_r0", 32'(sig[2]), 32'h0000);

        for (int r = 0; r < 6; r++) begin
            tab[3] = 16'($urandom);
            keep   = (r < 5) && ($urandom_range(0, 1) == 1);
            run_once(3, $urandom_range(0, 1) == 1, keep, sig_e);
        end

        reset_mid_run();
        tab[3] = 16'($urandom);
        run_once(3, 1'b1, 1'b0, sig_e);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
